// File: rtl/sm_fetch_queue.sv
// sm_fetch_queue: instruction fetch front-end.
// It drives the instruction ROM address and captures the combinational read
// data. Fetched words are buffered with their PCs in a small FIFO and handed
// to decode over a valid/ready handshake. It also handles PC redirects and
// halts fetch when the PC runs past the end of the ROM.
module sm_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_SIZE = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [31:0]               im_addr,
    input  logic [31:0]               im_data,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [31:0]               out_pc,
    output logic                      fetch_fault,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [31:0]       ROM_SIZE_C = 32'(ROM_SIZE);
    localparam logic [31:0]       WORD_MASK  = 32'hFFFF_FFFC;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fault_q, fault_d;
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic             pop_s;
    logic             in_range_s;
    logic             can_push_s;
    logic             push_s;

    // Handshake and push qualification; a redirect suppresses the push.
    always_comb begin
        out_valid  = (count_q != {CNT_W{1'b0}});
        pop_s      = out_valid & out_ready;
        in_range_s = ({2'b00, fetch_pc_q[31:2]} < ROM_SIZE_C);
        can_push_s = ~fault_q & in_range_s & ((count_q < DEPTH_C) | pop_s);
        push_s     = can_push_s & ~redirect_valid;
    end

    // Next-state logic: redirect flushes everything, otherwise push/pop/fault.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fault_d    = fault_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & WORD_MASK;
            rd_ptr_d   = {PTR_W{1'b0}};
            wr_ptr_d   = {PTR_W{1'b0}};
            count_d    = {CNT_W{1'b0}};
            fault_d    = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                wr_ptr_d   = wr_ptr_q;
                fetch_pc_d = fetch_pc_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // Fault latches once the PC leaves the ROM; only redirect/reset clear it.
            if (!in_range_s) begin
                fault_d = 1'b1;
            end else begin
                fault_d = fault_q;
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & WORD_MASK;
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    // FIFO storage; contents are only observed while the entry is counted valid.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= im_data;
        end
    end

    // Head outputs come from registered state only; forced to 0 when empty.
    always_comb begin
        if (out_valid) begin
            out_instr = instr_mem_q[rd_ptr_q];
            out_pc    = pc_mem_q[rd_ptr_q];
        end else begin
            out_instr = 32'h0000_0000;
            out_pc    = 32'h0000_0000;
        end
    end

    // ROM word address and status outputs.
    always_comb begin
        im_addr     = {2'b00, fetch_pc_q[31:2]};
        fetch_fault = fault_q;
        level       = count_q;
    end

endmodule

// File: tb/tb_sm_fetch_queue.sv
// Directed testbench for sm_fetch_queue with a behavioural ROM.
module tb_sm_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;
    logic [2:0]  level;

    logic [31:0] rom [128];
    int          n_chk;
    int          n_fail;

    sm_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .ROM_SIZE (128)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .im_addr        (im_addr),
        .im_data        (im_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault),
        .level          (level)
    );

    // Combinational ROM read; out-of-range reads return a marker value.
    assign im_data = (im_addr < 32'd128) ? rom[im_addr[6:0]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, out_instr, instr);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 128; i++) begin
            rom[i] = 32'hA000_0000 + 32'(i);
        end
        rom[0] = 32'h11;
        rom[1] = 32'h22;
        rom[2] = 32'h33;
        rom[3] = 32'h44;

        // Reset state
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        step();
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_imaddr", im_addr, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);

        // Streaming with out_ready high: one instruction per cycle
        rst = 1'b0;
        step();
        check_head("s0", 32'h0, 32'h11);
        check("s0_level", {29'd0, level}, 32'd1);
        step();
        check_head("s1", 32'h4, 32'h22);
        step();
        check_head("s2", 32'h8, 32'h33);
        step();
        check_head("s3", 32'hC, 32'h44);
        check("s3_level", {29'd0, level}, 32'd1);

        // Back-pressure: queue fills and fetch holds
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("full_level", {29'd0, level}, 32'd4);
        check("full_imaddr", im_addr, 32'd4);
        check_head("full_head", 32'h0, 32'h11);

        // Full with simultaneous push/pop: level stays 4, in-order drain
        out_ready = 1'b1;
        step();
        check_head("d1", 32'h4, 32'h22);
        check("d1_level", {29'd0, level}, 32'd4);
        step();
        check_head("d2", 32'h8, 32'h33);
        step();
        check_head("d3", 32'hC, 32'h44);
        step();
        check_head("d4", 32'h10, 32'hA000_0004);
        check("d4_level", {29'd0, level}, 32'd4);
        step();
        check_head("d5", 32'h14, 32'hA000_0005);

        // Redirect with 3 entries queued
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check("rd_pre_level", {29'd0, level}, 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        step();
        redirect_valid = 1'b0;
        check("rd_level", {29'd0, level}, 32'd0);
        check("rd_valid", {31'd0, out_valid}, 32'd0);
        check("rd_imaddr", im_addr, 32'h10);
        step();
        check_head("rd_first", 32'h40, 32'hA000_0010);
        check("rd_first_level", {29'd0, level}, 32'd1);

        // Redirect near the ROM end: fault after the last word
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1F8;
        step();
        redirect_valid = 1'b0;
        check("end_valid0", {31'd0, out_valid}, 32'd0);
        check("end_imaddr0", im_addr, 32'h7E);
        step();
        check_head("end_a", 32'h1F8, 32'hA000_007E);
        check("end_a_fault", {31'd0, fetch_fault}, 32'd0);
        step();
        check_head("end_b", 32'h1FC, 32'hA000_007F);
        check("end_b_fault", {31'd0, fetch_fault}, 32'd0);
        step();
        check("flt_fault", {31'd0, fetch_fault}, 32'd1);
        check("flt_valid", {31'd0, out_valid}, 32'd0);
        check("flt_level", {29'd0, level}, 32'd0);
        check("flt_imaddr", im_addr, 32'd128);
        step();
        check("flt_hold_fault", {31'd0, fetch_fault}, 32'd1);
        check("flt_hold_imaddr", im_addr, 32'd128);
        check("flt_hold_level", {29'd0, level}, 32'd0);

        // Redirect clears the fault and restarts at 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("clr_fault", {31'd0, fetch_fault}, 32'd0);
        check("clr_imaddr", im_addr, 32'd0);
        check("clr_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_head("clr_head", 32'h0, 32'h11);

        // Reset wins over a coincident redirect
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        check("rr_pre_level", {29'd0, level}, 32'd2);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        check("rr_valid", {31'd0, out_valid}, 32'd0);
        check("rr_level", {29'd0, level}, 32'd0);
        check("rr_imaddr", im_addr, 32'd0);
        step();
        check_head("rr_head", 32'h0, 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_fetch_queue.md
Name: sm_fetch_queue

Overview:
- Instruction fetch front-end sitting directly downstream of the per-node instruction ROM.
- Drives the ROM word address and captures the combinational read data.
- Buffers fetched words with their PCs in a small FIFO and presents them to the core's decode stage over a valid/ready handshake.
- Handles PC redirects (branches/jumps) with a queue flush, and flags fetches beyond the ROM bounds.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- ROM_SIZE, 128, number of 32-bit words in the attached ROM; must match the ROM's SIZE.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- im_addr  out  32  ROM word address, equal to fetch_pc[31:2]; combinational from fetch_pc.
- im_data  in  32  ROM read data for im_addr, valid in the same cycle.
- redirect_valid  in  1  one-cycle pulse: flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new byte PC; bits [1:0] ignored (treated as 0).
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at the queue head.
- out_pc  out  32  byte PC of the queue head.
- fetch_fault  out  1  fetch_pc word index >= ROM_SIZE; fetch halted.
- level  out  clog2(DEPTH)+1  current number of valid entries.

Behaviour:
- State:
  - fetch_pc (32 bit);
  - FIFO storage of {pc, instr}, DEPTH entries;
  - rd_ptr / wr_ptr, clog2(DEPTH) bits each, wrapping modulo DEPTH;
  - count, 0..DEPTH;
  - fault flag.
- Reset, when rst=1 at a clock edge:
  - fetch_pc=RESET_PC with bits [1:0] cleared;
  - pointers=0, count=0, fault=0;
  - resulting outputs: out_valid=0, level=0, fetch_fault=0, im_addr=RESET_PC>>2;
  - out_instr and out_pc read 0 while the queue is empty after reset.
  - Reset mid-operation discards all entries and any pending redirect.
- pop = out_valid & out_ready.
- can_push = !fault & (fetch_pc[31:2] < ROM_SIZE) & ((count < DEPTH) | pop).
- Normal cycle (no redirect):
  - If can_push: write {fetch_pc, im_data} at wr_ptr, advance wr_ptr, fetch_pc += 4 (wraps modulo 2^32).
  - If pop: advance rd_ptr.
  - count += can_push - pop. A simultaneous push and pop leaves count unchanged, including at count==DEPTH.
- Fault:
  - If fetch_pc[31:2] >= ROM_SIZE and no redirect, set fault and hold fetch_pc.
  - fetch_fault is registered: it asserts the cycle after the condition is first seen, and fetching stays halted.
  - The queue still drains normally; fault clears only on redirect or reset.
- Redirect:
  - Redirect has priority over push and pop.
  - On a redirect edge: count=0, rd_ptr=wr_ptr=0, fault=0, fetch_pc={redirect_pc[31:2],2'b00}, no push.
  - A pop coincident with a redirect counts as consumed by decode, but the remaining entries are discarded.
- Latency and flow:
  - Fetch-to-out_valid is 1 cycle: a word captured at edge N is visible at the head after edge N.
  - With out_ready held high, sustained throughput is one instruction per cycle.
  - After redirect: out_valid=0 for the cycle following the redirect edge; the first redirected instruction appears one cycle later.
- Full (count==DEPTH, no pop): no push; fetch_pc and im_addr are held stable.
- Empty (count==0): out_valid=0. out_instr/out_pc are don't-care but must not be X after reset. Empty + push: the entry is visible next cycle; there is no bypass.
- Head outputs out_valid/out_instr/out_pc come from registered FIFO state and depend only on registered state; out_ready has no combinational path to them.

Test Plan:
- Reset then out_ready=1, ROM words 0..3 = 0x11,0x22,0x33,0x44 -> out_valid rises 1 cycle after reset release; out (pc,instr) = (0,0x11),(4,0x22),(8,0x33),(C,0x44) on consecutive cycles.
- out_ready=0 for 10 cycles after reset -> level stops at 4, im_addr held at 4; raise out_ready -> entries PC 0,4,8,C drain in order, then fetch resumes at PC 0x10 with no gap or duplicate.
- Queue full with out_ready=1 (simultaneous push/pop at count==DEPTH) -> level stays 4 and one instruction per cycle emerges.
- redirect_valid with redirect_pc=0x43 while 3 entries are queued -> next cycle level=0, out_valid=0; following cycle out_pc=0x40, out_instr=rom[16].
- redirect_pc=0x1F8 with ROM_SIZE=128 -> PCs 0x1F8 and 0x1FC are delivered, then fetch_fault=1 and im_addr holds 128; redirect to 0x0 clears fetch_fault and fetch restarts at PC 0.
- rst asserted with 2 entries queued and a redirect pulse in the same cycle -> next cycle out_valid=0, level=0, im_addr=RESET_PC>>2; the redirect is ignored.
